// File: rtl/gray_step_decoder.sv
// -----------------------------------------------------------------------------
// gray_step_decoder
//   Consumer side of a Gray up/down counter link. Synchronizes an asynchronous
//   Gray bus, decodes it to binary and classifies every change as +1, -1 or an
//   illegal jump. Keeps a wrapping position count and a saturating error count.
//
// Ports
//   clk      : system clock, rising edge
//   areset   : asynchronous reset, active-high
//   gray_in  : Gray-coded input, may change asynchronously to clk
//   clr_err  : synchronous clear of err_cnt
//   bin_out  : binary value of the last accepted sample
//   pos      : accumulated position, mod 2^POS_W
//   step_up  : one-cycle pulse on an accepted +1 step
//   step_dn  : one-cycle pulse on an accepted -1 step
//   err      : one-cycle pulse on an illegal transition
//   err_cnt  : saturating count of illegal transitions
//   locked   : high while tracking (no outstanding fault)
// -----------------------------------------------------------------------------
module gray_step_decoder #(
   parameter int GW    = 3,
   parameter int POS_W = 8,
   parameter int ERR_W = 4
) (
   input  logic             clk,
   input  logic             areset,
   input  logic [GW-1:0]    gray_in,
   input  logic             clr_err,
   output logic [GW-1:0]    bin_out,
   output logic [POS_W-1:0] pos,
   output logic             step_up,
   output logic             step_dn,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             locked
);

   typedef enum logic [1:0] {ACQ, TRACK, FAULT} state_t;

   state_t        state;
   logic [1:0]    acq_cnt;
   logic [GW-1:0] sync1, sync2, prev_bin;
   logic [GW-1:0] b_new, delta;
   logic          is_hold, is_up, is_dn, illegal_evt;

   // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      b_new = '0;
      b_new[GW-1] = sync2[GW-1];
      for (int i = GW-2; i >= 0; i--)
         b_new[i] = b_new[i+1] ^ sync2[i];
   end

   // Modular difference makes the max-code <-> zero-code wrap a legal +-1.
   assign delta       = b_new - prev_bin;
   assign is_hold     = (delta == '0);
   assign is_up       = (delta == GW'(1));
   assign is_dn       = (delta == '1);
   assign illegal_evt = (state != ACQ) && !is_hold && !is_up && !is_dn;

   assign bin_out = prev_bin;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state    <= ACQ;
         acq_cnt  <= '0;
         sync1    <= '0;
         sync2    <= '0;
         prev_bin <= '0;
         pos      <= '0;
         err_cnt  <= '0;
         step_up  <= 1'b0;
         step_dn  <= 1'b0;
         err      <= 1'b0;
         locked   <= 1'b0;
      end else begin
         sync1   <= gray_in;
         sync2   <= sync1;
         step_up <= 1'b0;
         step_dn <= 1'b0;
         err     <= 1'b0;

         case (state)
            // Two edges fill the synchronizer; the third takes the current
            // input as origin without reporting a step.
            ACQ: begin
               if (acq_cnt == 2'd2) begin
                  prev_bin <= b_new;
                  state    <= TRACK;
                  locked   <= 1'b1;
               end else begin
                  acq_cnt <= acq_cnt + 2'd1;
               end
            end
            TRACK, FAULT: begin
               if (is_up) begin
                  pos      <= pos + POS_W'(1);
                  step_up  <= 1'b1;
                  prev_bin <= b_new;
                  state    <= TRACK;
                  locked   <= 1'b1;
               end else if (is_dn) begin
                  pos      <= pos - POS_W'(1);
                  step_dn  <= 1'b1;
                  prev_bin <= b_new;
                  state    <= TRACK;
                  locked   <= 1'b1;
               end else if (!is_hold) begin
                  // Resynchronize to the new code so one glitch yields one error.
                  err      <= 1'b1;
                  prev_bin <= b_new;
                  state    <= FAULT;
                  locked   <= 1'b0;
               end
            end
            default: begin
               state  <= ACQ;
               locked <= 1'b0;
            end
         endcase

         // Clear takes priority, but a same-cycle error is still counted.
         if (clr_err)
            err_cnt <= illegal_evt ? ERR_W'(1) : '0;
         else if (illegal_evt && (err_cnt != '1))
            err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_gray_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_step_decoder
//   Directed-vector bench for gray_step_decoder (GW=3, POS_W=8, ERR_W=4).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
//   A change applied before rising edge N is reported after edge N+2.
// -----------------------------------------------------------------------------
module tb_gray_step_decoder;

   logic       clk = 1'b0;
   logic       areset;
   logic [2:0] gray_in;
   logic       clr_err;
   logic [2:0] bin_out;
   logic [7:0] pos;
   logic       step_up, step_dn, err;
   logic [3:0] err_cnt;
   logic       locked;

   int total = 0;
   int bad   = 0;
   int up_cnt = 0, dn_cnt = 0, err_pc = 0, excl_bad = 0;

   gray_step_decoder #(.GW(3), .POS_W(8), .ERR_W(4)) dut (
      .clk     (clk),
      .areset  (areset),
      .gray_in (gray_in),
      .clr_err (clr_err),
      .bin_out (bin_out),
      .pos     (pos),
      .step_up (step_up),
      .step_dn (step_dn),
      .err     (err),
      .err_cnt (err_cnt),
      .locked  (locked)
   );

   always #5 clk = ~clk;

   // Pulse tallies; each pulse is one cycle wide so one sample per cycle.
   always @(negedge clk) begin
      if (step_up) up_cnt++;
      if (step_dn) dn_cnt++;
      if (err)     err_pc++;
      if ((int'(step_up) + int'(step_dn) + int'(err)) > 1) excl_bad++;
   end

   // Apply a code and stop at the sample point where its result is visible.
   task automatic put(input logic [2:0] g);
      @(negedge clk);
      gray_in = g;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      int u0, d0, e0;
      areset = 1'b1; gray_in = 3'b000; clr_err = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bin_out, pos, step_up, step_dn, err, err_cnt, locked} !== 19'd0) begin
         bad++; $display("FAIL reset_outputs: got %0h want 0",
                         {bin_out, pos, step_up, step_dn, err, err_cnt, locked});
      end
      areset = 1'b0;
      u0 = up_cnt; d0 = dn_cnt; e0 = err_pc;
      repeat (2) @(negedge clk);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked_edge2: got %0b want 0", locked); end
      @(negedge clk);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL reset_locked_edge3: got %0b want 1", locked); end
      total++;
      if (pos !== 8'd0 || bin_out !== 3'd0) begin
         bad++; $display("FAIL reset_pos_bin: got pos=%0d bin=%0d want 0 0", pos, bin_out);
      end
      total++;
      if (up_cnt != u0 || dn_cnt != d0 || err_pc != e0) begin
         bad++; $display("FAIL reset_no_pulses: got %0d pulses want 0",
                         (up_cnt - u0) + (dn_cnt - d0) + (err_pc - e0));
      end
   endtask

   task automatic test_up_walk;
      logic [2:0] seq [8];
      int u0;
      seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      u0 = up_cnt;
      for (int i = 0; i < 8; i++) begin
         put(seq[i]);
         total++;
         if (step_up !== 1'b1 || bin_out !== 3'((i + 1) % 8)) begin
            bad++; $display("FAIL up_step%0d: got up=%0b bin=%0d want 1 %0d",
                            i, step_up, bin_out, (i + 1) % 8);
         end
      end
      @(negedge clk);
      total++;
      if (step_up !== 1'b0) begin bad++; $display("FAIL up_pulse_width: got %0b want 0", step_up); end
      total++;
      if (up_cnt - u0 != 8 || pos !== 8'd8 || err_cnt !== 4'd0) begin
         bad++; $display("FAIL up_totals: got ups=%0d pos=%0d errs=%0d want 8 8 0",
                         up_cnt - u0, pos, err_cnt);
      end
   endtask

   task automatic test_down;
      put(3'b100);
      total++;
      if (step_dn !== 1'b1 || pos !== 8'd7 || bin_out !== 3'd7) begin
         bad++; $display("FAIL down_wrapcode: got dn=%0b pos=%0d bin=%0d want 1 7 7", step_dn, pos, bin_out);
      end
      put(3'b101);
      total++;
      if (step_dn !== 1'b1 || pos !== 8'd6 || bin_out !== 3'd6) begin
         bad++; $display("FAIL down_second: got dn=%0b pos=%0d bin=%0d want 1 6 6", step_dn, pos, bin_out);
      end
      // Re-origin at code 000 so the position starts at zero, then step down.
      @(negedge clk);
      areset = 1'b1; gray_in = 3'b000;
      @(negedge clk);
      areset = 1'b0;
      repeat (3) @(negedge clk);
      put(3'b100);
      total++;
      if (step_dn !== 1'b1 || pos !== 8'd255 || bin_out !== 3'd7) begin
         bad++; $display("FAIL down_pos_wrap: got dn=%0b pos=%0d bin=%0d want 1 255 7", step_dn, pos, bin_out);
      end
   endtask

   task automatic test_illegal;
      put(3'b000);
      total++;
      if (step_up !== 1'b1 || pos !== 8'd0) begin
         bad++; $display("FAIL ill_setup: got up=%0b pos=%0d want 1 0", step_up, pos);
      end
      put(3'b011);
      total++;
      if (err !== 1'b1 || err_cnt !== 4'd1 || locked !== 1'b0 || pos !== 8'd0 || bin_out !== 3'd2
          || step_up !== 1'b0 || step_dn !== 1'b0) begin
         bad++; $display("FAIL ill_jump: got err=%0b cnt=%0d lk=%0b pos=%0d bin=%0d want 1 1 0 0 2",
                         err, err_cnt, locked, pos, bin_out);
      end
      put(3'b001);
      total++;
      if (step_dn !== 1'b1 || pos !== 8'd255 || locked !== 1'b1 || bin_out !== 3'd1 || err !== 1'b0) begin
         bad++; $display("FAIL ill_recover: got dn=%0b pos=%0d lk=%0b bin=%0d want 1 255 1 1",
                         step_dn, pos, locked, bin_out);
      end
   endtask

   task automatic test_saturate;
      int e0;
      put(3'b000);
      total++;
      if (step_dn !== 1'b1 || pos !== 8'd254) begin
         bad++; $display("FAIL sat_setup: got dn=%0b pos=%0d want 1 254", step_dn, pos);
      end
      e0 = err_pc;
      for (int i = 0; i < 20; i++) put((i % 2 == 0) ? 3'b011 : 3'b000);
      @(negedge clk);
      total++;
      if (err_cnt !== 4'd15 || err_pc - e0 != 20 || locked !== 1'b0) begin
         bad++; $display("FAIL sat_count: got cnt=%0d pulses=%0d lk=%0b want 15 20 0",
                         err_cnt, err_pc - e0, locked);
      end
      // clr_err lands on the same edge as the next illegal event.
      gray_in = 3'b011;
      repeat (2) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      total++;
      if (err !== 1'b1 || err_cnt !== 4'd1 || pos !== 8'd254) begin
         bad++; $display("FAIL sat_clr_coincident: got err=%0b cnt=%0d pos=%0d want 1 1 254", err, err_cnt, pos);
      end
   endtask

   task automatic test_areset_mid;
      int u0, d0, e0;
      put(3'b110);
      total++;
      if (err !== 1'b1 || err_cnt !== 4'd2 || bin_out !== 3'd4) begin
         bad++; $display("FAIL mid_fault: got err=%0b cnt=%0d bin=%0d want 1 2 4", err, err_cnt, bin_out);
      end
      @(negedge clk);
      #2 areset = 1'b1;
      #1;
      total++;
      if ({bin_out, pos, step_up, step_dn, err, err_cnt, locked} !== 19'd0) begin
         bad++; $display("FAIL mid_async_clear: got %0h want 0",
                         {bin_out, pos, step_up, step_dn, err, err_cnt, locked});
      end
      @(negedge clk);
      areset = 1'b0;
      u0 = up_cnt; d0 = dn_cnt; e0 = err_pc;
      repeat (2) @(negedge clk);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked_edge2: got %0b want 0", locked); end
      @(negedge clk);
      total++;
      if (locked !== 1'b1 || bin_out !== 3'd4 || pos !== 8'd0 || err_cnt !== 4'd0) begin
         bad++; $display("FAIL mid_reacquire: got lk=%0b bin=%0d pos=%0d cnt=%0d want 1 4 0 0",
                         locked, bin_out, pos, err_cnt);
      end
      total++;
      if (up_cnt != u0 || dn_cnt != d0 || err_pc != e0) begin
         bad++; $display("FAIL mid_no_pulses: got %0d pulses want 0",
                         (up_cnt - u0) + (dn_cnt - d0) + (err_pc - e0));
      end
   endtask

   initial begin
      test_reset;
      test_up_walk;
      test_down;
      test_illegal;
      test_saturate;
      test_areset_mid;
      total++;
      if (excl_bad != 0) begin bad++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", excl_bad); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
